// File: rtl/alu_multicycle_if.sv
// Handshake bundle for alu_multicycle: request side (operands, opcode) and
// result side (value, high product half, flags) with valid/ready on each.
interface alu_multicycle_if #(
   parameter int WIDTH = 32
);
   logic             in_valid;
   logic             in_ready;
   logic [3:0]       alucon;
   logic [WIDTH-1:0] A;
   logic [WIDTH-1:0] B;
   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] result;
   logic [WIDTH-1:0] result_hi;
   logic             zero;
   logic             carry;
   logic             overflow;

   modport master (
      output in_valid, alucon, A, B, out_ready,
      input  in_ready, out_valid, result, result_hi, zero, carry, overflow
   );

   modport slave (
      input  in_valid, alucon, A, B, out_ready,
      output in_ready, out_valid, result, result_hi, zero, carry, overflow
   );
endinterface

// File: rtl/alu_multicycle.sv
// Handshaked ALU: single-cycle arithmetic/logic/compare ops plus an iterative
// shift-add unsigned multiplier producing a 2*WIDTH product.
module alu_multicycle #(
   parameter int WIDTH = 32
) (
   input logic             clk,
   input logic             rst,
   alu_multicycle_if.slave bus
);
   localparam int CNT_W = $clog2(WIDTH + 1);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

   localparam logic [3:0] OP_ADD  = 4'b0000;
   localparam logic [3:0] OP_SUB  = 4'b0001;
   localparam logic [3:0] OP_AND  = 4'b0010;
   localparam logic [3:0] OP_OR   = 4'b0011;
   localparam logic [3:0] OP_XOR  = 4'b0100;
   localparam logic [3:0] OP_NOR  = 4'b0101;
   localparam logic [3:0] OP_SLT  = 4'b0110;
   localparam logic [3:0] OP_SLTU = 4'b0111;
   localparam logic [3:0] OP_MULU = 4'b1000;

   typedef enum logic [1:0] {S_IDLE, S_MUL, S_DONE} state_t;

   state_t             state_q, state_d;
   logic [WIDTH-1:0]   result_q, result_d;
   logic [WIDTH-1:0]   result_hi_q, result_hi_d;
   logic               zero_q, zero_d;
   logic               carry_q, carry_d;
   logic               overflow_q, overflow_d;
   logic [WIDTH-1:0]   mcand_q, mcand_d;
   logic [WIDTH-1:0]   mplier_q, mplier_d;
   logic [2*WIDTH-1:0] acc_q, acc_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;

   logic               in_ready;
   logic               handshake;
   logic               is_sub;
   logic [WIDTH-1:0]   b_eff;
   logic [WIDTH:0]     add_full;
   logic [WIDTH-1:0]   alu_res;
   logic               alu_c;
   logic               alu_v;
   logic [WIDTH-1:0]   mul_addend;
   logic [WIDTH:0]     mul_sum;
   logic [2*WIDTH-1:0] acc_shift;

   assign in_ready  = !rst && (state_q == S_IDLE || (state_q == S_DONE && bus.out_ready));
   assign handshake = bus.in_valid && in_ready;

   // SUB shares the adder by inverting B and injecting a carry-in of 1.
   assign is_sub   = (bus.alucon == OP_SUB);
   assign b_eff    = is_sub ? ~bus.B : bus.B;
   assign add_full = {1'b0, bus.A} + {1'b0, b_eff} + (WIDTH+1)'(is_sub);

   always_comb begin
      alu_res = '0;
      alu_c   = 1'b0;
      alu_v   = 1'b0;
      case (bus.alucon)
         OP_ADD, OP_SUB: begin
            alu_res = add_full[WIDTH-1:0];
            alu_c   = add_full[WIDTH];
            alu_v   = (bus.A[WIDTH-1] == b_eff[WIDTH-1]) &&
                      (add_full[WIDTH-1] != bus.A[WIDTH-1]);
         end
         OP_AND:  alu_res = bus.A & bus.B;
         OP_OR:   alu_res = bus.A | bus.B;
         OP_XOR:  alu_res = bus.A ^ bus.B;
         OP_NOR:  alu_res = ~(bus.A | bus.B);
         OP_SLT:  alu_res = {{(WIDTH-1){1'b0}}, ($signed(bus.A) < $signed(bus.B))};
         OP_SLTU: alu_res = {{(WIDTH-1){1'b0}}, (bus.A < bus.B)};
         default: alu_res = '0;
      endcase
   end

   // One shift-add step: the adder carry becomes the new accumulator MSB.
   assign mul_addend = mplier_q[0] ? mcand_q : '0;
   assign mul_sum    = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + {1'b0, mul_addend};
   assign acc_shift  = {mul_sum, acc_q[WIDTH-1:1]};

   always_comb begin
      state_d     = state_q;
      result_d    = result_q;
      result_hi_d = result_hi_q;
      zero_d      = zero_q;
      carry_d     = carry_q;
      overflow_d  = overflow_q;
      mcand_d     = mcand_q;
      mplier_d    = mplier_q;
      acc_d       = acc_q;
      cnt_d       = cnt_q;
      case (state_q)
         S_IDLE, S_DONE: begin
            if (state_q == S_DONE && bus.out_ready) begin
               state_d = S_IDLE;
            end
            if (handshake) begin
               if (bus.alucon == OP_MULU) begin
                  mcand_d  = bus.A;
                  mplier_d = bus.B;
                  acc_d    = '0;
                  cnt_d    = '0;
                  state_d  = S_MUL;
               end else begin
                  result_d    = alu_res;
                  result_hi_d = '0;
                  zero_d      = (alu_res == '0);
                  carry_d     = alu_c;
                  overflow_d  = alu_v;
                  state_d     = S_DONE;
               end
            end
         end
         S_MUL: begin
            acc_d    = acc_shift;
            mplier_d = mplier_q >> 1;
            cnt_d    = cnt_q + CNT_W'(1);
            if (cnt_q == CNT_LAST) begin
               result_d    = acc_shift[WIDTH-1:0];
               result_hi_d = acc_shift[2*WIDTH-1:WIDTH];
               zero_d      = (acc_shift == '0);
               carry_d     = (acc_shift[2*WIDTH-1:WIDTH] != '0);
               overflow_d  = 1'b0;
               state_d     = S_DONE;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= S_IDLE;
         result_q    <= '0;
         result_hi_q <= '0;
         zero_q      <= 1'b0;
         carry_q     <= 1'b0;
         overflow_q  <= 1'b0;
         mcand_q     <= '0;
         mplier_q    <= '0;
         acc_q       <= '0;
         cnt_q       <= '0;
      end else begin
         state_q     <= state_d;
         result_q    <= result_d;
         result_hi_q <= result_hi_d;
         zero_q      <= zero_d;
         carry_q     <= carry_d;
         overflow_q  <= overflow_d;
         mcand_q     <= mcand_d;
         mplier_q    <= mplier_d;
         acc_q       <= acc_d;
         cnt_q       <= cnt_d;
      end
   end

   assign bus.in_ready  = in_ready;
   assign bus.out_valid = (state_q == S_DONE);
   assign bus.result    = result_q;
   assign bus.result_hi = result_hi_q;
   assign bus.zero      = zero_q;
   assign bus.carry     = carry_q;
   assign bus.overflow  = overflow_q;
endmodule

// File: tb/tb_alu_multicycle.sv
// Directed-vector bench for alu_multicycle: 32-bit instance for all ops and
// handshake corner cases, 8-bit instance for the narrow multiply.
module tb_alu_multicycle;
   localparam logic [3:0] OP_ADD  = 4'b0000;
   localparam logic [3:0] OP_SUB  = 4'b0001;
   localparam logic [3:0] OP_AND  = 4'b0010;
   localparam logic [3:0] OP_OR   = 4'b0011;
   localparam logic [3:0] OP_XOR  = 4'b0100;
   localparam logic [3:0] OP_NOR  = 4'b0101;
   localparam logic [3:0] OP_SLT  = 4'b0110;
   localparam logic [3:0] OP_SLTU = 4'b0111;
   localparam logic [3:0] OP_MULU = 4'b1000;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   total = 0;
   int   bad   = 0;

   always #5 clk = ~clk;

   alu_multicycle_if #(.WIDTH(32)) bus32 ();
   alu_multicycle_if #(.WIDTH(8))  bus8 ();

   alu_multicycle #(.WIDTH(32)) dut32 (.clk(clk), .rst(rst), .bus(bus32.slave));
   alu_multicycle #(.WIDTH(8))  dut8  (.clk(clk), .rst(rst), .bus(bus8.slave));

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   // Present a request at a falling edge; the handshake happens on the next
   // rising edge, and we return at the falling edge of cycle 1 with junk operands.
   task automatic issue(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
      bus32.in_valid = 1'b1;
      bus32.alucon   = op;
      bus32.A        = a;
      bus32.B        = b;
      #1;
      check("issue_ready", 64'(bus32.in_ready), 64'd1);
      @(negedge clk);
      bus32.in_valid = 1'b0;
      bus32.alucon   = 4'hF;
      bus32.A        = $urandom;
      bus32.B        = $urandom;
   endtask

   task automatic op_check(input string tag, input logic [3:0] op, input logic [31:0] a,
                           input logic [31:0] b, input logic [31:0] exp_res,
                           input logic exp_z, input logic exp_c, input logic exp_v);
      $display("txn %s op=%0h a=%h b=%h exp=%h", tag, op, a, b, exp_res);
      issue(op, a, b);
      check({tag, "_valid"}, 64'(bus32.out_valid), 64'd1);
      check({tag, "_res"},   64'(bus32.result), 64'(exp_res));
      check({tag, "_hi"},    64'(bus32.result_hi), 64'd0);
      check({tag, "_z"},     64'(bus32.zero), 64'(exp_z));
      check({tag, "_c"},     64'(bus32.carry), 64'(exp_c));
      check({tag, "_v"},     64'(bus32.overflow), 64'(exp_v));
   endtask

   task automatic mul_check(input string tag, input logic [31:0] a, input logic [31:0] b,
                            input logic [31:0] exp_hi, input logic [31:0] exp_lo,
                            input logic exp_z, input logic exp_c);
      $display("txn %s op=MULU a=%h b=%h exp=%h_%h", tag, a, b, exp_hi, exp_lo);
      issue(OP_MULU, a, b);
      for (int i = 1; i <= 32; i++) begin
         check({tag, "_busy_rdy"}, 64'(bus32.in_ready), 64'd0);
         check({tag, "_busy_vld"}, 64'(bus32.out_valid), 64'd0);
         @(negedge clk);
      end
      check({tag, "_valid"}, 64'(bus32.out_valid), 64'd1);
      check({tag, "_hi"},    64'(bus32.result_hi), 64'(exp_hi));
      check({tag, "_lo"},    64'(bus32.result), 64'(exp_lo));
      check({tag, "_z"},     64'(bus32.zero), 64'(exp_z));
      check({tag, "_c"},     64'(bus32.carry), 64'(exp_c));
      check({tag, "_v"},     64'(bus32.overflow), 64'd0);
   endtask

   initial begin
      bus32.in_valid = 1'b0; bus32.alucon = OP_ADD; bus32.A = '0; bus32.B = '0;
      bus32.out_ready = 1'b1;
      bus8.in_valid = 1'b0; bus8.alucon = OP_ADD; bus8.A = '0; bus8.B = '0;
      bus8.out_ready = 1'b1;

      repeat (3) @(negedge clk);
      $display("txn reset");
      check("rst_ready", 64'(bus32.in_ready), 64'd0);
      check("rst_valid", 64'(bus32.out_valid), 64'd0);
      check("rst_res",   64'(bus32.result), 64'd0);
      check("rst_hi",    64'(bus32.result_hi), 64'd0);
      check("rst_flags", {61'd0, bus32.zero, bus32.carry, bus32.overflow}, 64'd0);
      rst = 1'b0;

      mul_check("mul_ff", 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, 1'b0, 1'b1);
      mul_check("mul_3x5", 32'd3, 32'd5, 32'd0, 32'd15, 1'b0, 1'b0);
      mul_check("mul_2p32", 32'h0001_0000, 32'h0001_0000, 32'd1, 32'd0, 1'b0, 1'b1);
      mul_check("mul_zero", 32'd0, 32'hDEAD_BEEF, 32'd0, 32'd0, 1'b1, 1'b0);

      op_check("add_ovf",  OP_ADD,  32'h7FFF_FFFF, 32'd1, 32'h8000_0000, 1'b0, 1'b0, 1'b1);
      op_check("add_wrap", OP_ADD,  32'hFFFF_FFFF, 32'd1, 32'd0, 1'b1, 1'b1, 1'b0);
      op_check("sub_brw",  OP_SUB,  32'd5, 32'd7, 32'hFFFF_FFFE, 1'b0, 1'b0, 1'b0);
      op_check("sub_eq",   OP_SUB,  32'h1234, 32'h1234, 32'd0, 1'b1, 1'b1, 1'b0);
      op_check("sub_ovf",  OP_SUB,  32'h8000_0000, 32'd1, 32'h7FFF_FFFF, 1'b0, 1'b1, 1'b1);
      op_check("and",      OP_AND,  32'hF0F0_1234, 32'h0FF0_FF00, 32'h00F0_1200, 1'b0, 1'b0, 1'b0);
      op_check("or",       OP_OR,   32'hF000_0001, 32'h0F00_0010, 32'hFF00_0011, 1'b0, 1'b0, 1'b0);
      op_check("xor_eq",   OP_XOR,  32'hA5A5_5A5A, 32'hA5A5_5A5A, 32'd0, 1'b1, 1'b0, 1'b0);
      op_check("nor",      OP_NOR,  32'h0000_00FF, 32'hFF00_0000, 32'h00FF_FF00, 1'b0, 1'b0, 1'b0);
      op_check("slt",      OP_SLT,  32'hFFFF_FFFF, 32'd1, 32'd1, 1'b0, 1'b0, 1'b0);
      op_check("sltu",     OP_SLTU, 32'hFFFF_FFFF, 32'd1, 32'd0, 1'b1, 1'b0, 1'b0);
      op_check("undef",    4'b1011, 32'h1234_5678, 32'h1111_1111, 32'd0, 1'b1, 1'b0, 1'b0);

      // Back-to-back single-cycle ops with out_ready held high.
      op_check("b2b_a", OP_ADD, 32'd1, 32'd2, 32'd3, 1'b0, 1'b0, 1'b0);
      op_check("b2b_b", OP_ADD, 32'd10, 32'd20, 32'd30, 1'b0, 1'b0, 1'b0);

      // Drain to IDLE, then hold a result under backpressure.
      @(negedge clk);
      check("drain_valid", 64'(bus32.out_valid), 64'd0);
      check("drain_keep",  64'(bus32.result), 64'd30);
      bus32.out_ready = 1'b0;
      $display("txn backpressure add 3+4");
      issue(OP_ADD, 32'd3, 32'd4);
      for (int i = 0; i < 5; i++) begin
         check("bp_res",   64'(bus32.result), 64'd7);
         check("bp_valid", 64'(bus32.out_valid), 64'd1);
         check("bp_ready", 64'(bus32.in_ready), 64'd0);
         @(negedge clk);
      end
      bus32.out_ready = 1'b1;
      $display("txn release with add 1+1");
      issue(OP_ADD, 32'd1, 32'd1);
      check("rel_res",   64'(bus32.result), 64'd2);
      check("rel_valid", 64'(bus32.out_valid), 64'd1);
      @(negedge clk);
      check("idle_valid", 64'(bus32.out_valid), 64'd0);
      check("idle_keep",  64'(bus32.result), 64'd2);

      // Reset in the middle of a multiply.
      $display("txn mulu aborted by reset");
      issue(OP_MULU, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
      repeat (9) @(negedge clk);
      rst = 1'b1;
      #1;
      check("abort_rdy_in_rst", 64'(bus32.in_ready), 64'd0);
      @(negedge clk);
      check("abort_valid", 64'(bus32.out_valid), 64'd0);
      check("abort_res",   64'(bus32.result), 64'd0);
      check("abort_hi",    64'(bus32.result_hi), 64'd0);
      check("abort_flags", {61'd0, bus32.zero, bus32.carry, bus32.overflow}, 64'd0);
      rst = 1'b0;
      op_check("post_rst", OP_ADD, 32'd1, 32'd2, 32'd3, 1'b0, 1'b0, 1'b0);
      @(negedge clk);
      check("post_idle", 64'(bus32.out_valid), 64'd0);

      // Narrow multiplier: 0xFF * 0xFF = 0xFE01, valid in cycle 9.
      $display("txn w8 mulu ff*ff");
      bus8.in_valid = 1'b1;
      bus8.alucon   = OP_MULU;
      bus8.A        = 8'hFF;
      bus8.B        = 8'hFF;
      #1;
      check("w8_ready", 64'(bus8.in_ready), 64'd1);
      @(negedge clk);
      bus8.in_valid = 1'b0;
      bus8.A        = 8'h00;
      bus8.B        = 8'h00;
      for (int i = 1; i <= 8; i++) begin
         check("w8_busy_rdy", 64'(bus8.in_ready), 64'd0);
         check("w8_busy_vld", 64'(bus8.out_valid), 64'd0);
         @(negedge clk);
      end
      check("w8_valid", 64'(bus8.out_valid), 64'd1);
      check("w8_hi",    64'(bus8.result_hi), 64'hFE);
      check("w8_lo",    64'(bus8.result), 64'h01);
      check("w8_c",     64'(bus8.carry), 64'd1);
      check("w8_z",     64'(bus8.zero), 64'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
